// File: rtl/unidade_pc_if.sv
// Control/status bundle of the program-counter unit: next-PC requests in, PC and stack status out.
interface unidade_pc_if #(
    parameter int LARGURA = 32
);
    logic                       parar;
    logic                       desvio;
    logic signed [LARGURA-1:0]  deslocamento;
    logic                       salto;
    logic                       chamada;
    logic                       retorno;
    logic        [LARGURA-1:0]  alvo;
    logic        [LARGURA-1:0]  pc_atual;
    logic        [LARGURA-1:0]  pc_mais;
    logic                       pilha_vazia;
    logic                       pilha_cheia;
    logic                       erro_pilha;

    modport master (
        output parar, desvio, deslocamento, salto, chamada, retorno, alvo,
        input  pc_atual, pc_mais, pilha_vazia, pilha_cheia, erro_pilha
    );

    modport slave (
        input  parar, desvio, deslocamento, salto, chamada, retorno, alvo,
        output pc_atual, pc_mais, pilha_vazia, pilha_cheia, erro_pilha
    );
endinterface

// File: rtl/unidade_pc.sv
// MIPS program-counter unit: PC register, next-PC selection and a circular return-address stack.
module unidade_pc #(
    parameter int                 LARGURA      = 32,
    parameter int                 INCREMENTO   = 1,
    parameter logic [LARGURA-1:0] END_RESET    = '0,
    parameter int                 PROFUNDIDADE = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    unidade_pc_if.slave     bus
);
    localparam int PW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int CW = $clog2(PROFUNDIDADE + 1);
    localparam logic [LARGURA-1:0] INC_W   = LARGURA'(INCREMENTO);
    localparam logic [CW-1:0]      CHEIO_C = CW'(PROFUNDIDADE);

    logic [LARGURA-1:0] pc_p0;
    logic [PW-1:0]      topo_p0;
    logic [CW-1:0]      conta_p0;
    logic               vazia_p0, cheia_p0, erro_p0;
    logic [LARGURA-1:0] pilha [PROFUNDIDADE];

    logic [LARGURA-1:0] pc_mais_w, pc_prox;
    logic [PW-1:0]      topo_prox, topo_ant, topo_seg;
    logic [CW-1:0]      conta_prox;
    logic               erro_prox, empilha;

    function automatic logic [PW-1:0] avanca(input logic [PW-1:0] p);
        return (p == PW'(PROFUNDIDADE - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] recua(input logic [PW-1:0] p);
        return (p == '0) ? PW'(PROFUNDIDADE - 1) : p - PW'(1);
    endfunction

    // Offset is two's complement, so modular addition of its bit pattern is the signed sum.
    function automatic logic [LARGURA-1:0] soma_desvio(input logic [LARGURA-1:0] base,
                                                       input logic signed [LARGURA-1:0] desl);
        return base + $unsigned(desl);
    endfunction

    assign pc_mais_w = pc_p0 + INC_W;
    assign topo_ant  = recua(topo_p0);
    assign topo_seg  = avanca(topo_p0);

    // topo_p0 is the next free slot; when full it also addresses the oldest entry.
    always_comb begin
        pc_prox    = pc_mais_w;
        topo_prox  = topo_p0;
        conta_prox = conta_p0;
        erro_prox  = erro_p0;
        empilha    = 1'b0;
        if (bus.parar) begin
            pc_prox = pc_p0;
        end else if (bus.retorno) begin
            if (conta_p0 == '0) begin
                erro_prox = 1'b1;
            end else begin
                pc_prox    = pilha[topo_ant];
                topo_prox  = topo_ant;
                conta_prox = conta_p0 - CW'(1);
            end
        end else if (bus.chamada) begin
            pc_prox   = bus.alvo;
            empilha   = 1'b1;
            topo_prox = topo_seg;
            if (conta_p0 == CHEIO_C) erro_prox = 1'b1;
            else                     conta_prox = conta_p0 + CW'(1);
        end else if (bus.salto) begin
            pc_prox = bus.alvo;
        end else if (bus.desvio) begin
            pc_prox = soma_desvio(pc_mais_w, bus.deslocamento);
        end
    end

    // Stage p0: PC, stack pointer, occupancy and flags.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_p0    <= END_RESET;
            topo_p0  <= '0;
            conta_p0 <= '0;
            vazia_p0 <= 1'b1;
            cheia_p0 <= 1'b0;
            erro_p0  <= 1'b0;
        end else begin
            pc_p0    <= pc_prox;
            topo_p0  <= topo_prox;
            conta_p0 <= conta_prox;
            vazia_p0 <= (conta_prox == '0);
            cheia_p0 <= (conta_prox == CHEIO_C);
            erro_p0  <= erro_prox;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && empilha) pilha[topo_p0] <= pc_mais_w;
    end

    assign bus.pc_atual    = pc_p0;
    assign bus.pc_mais     = pc_mais_w;
    assign bus.pilha_vazia = vazia_p0;
    assign bus.pilha_cheia = cheia_p0;
    assign bus.erro_pilha  = erro_p0;
endmodule

// File: tb/tb_unidade_pc.sv
// Scoreboard bench for unidade_pc: a queue-based reference model predicts each cycle's state.
module tb_unidade_pc;
    localparam logic [31:0] END_R = 32'h100;
    localparam int          PROF  = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    unidade_pc_if #(.LARGURA(32)) b();

    unidade_pc #(
        .LARGURA(32), .INCREMENTO(1), .END_RESET(END_R), .PROFUNDIDADE(PROF)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(b)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] mais;
        logic        vazia;
        logic        cheia;
        logic        erro;
    } esperado_t;

    esperado_t   fila[$];
    logic [31:0] m_pilha[$];
    logic [31:0] m_pc = END_R;
    logic        m_erro = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nome, act, exp, $time);
        end
    endtask

    // Reference model: return stack is a plain queue, oldest entry at the front.
    task automatic modelo(input logic rn, pa, re, ch, sa, de, input logic [31:0] ds, al);
        esperado_t e;
        if (!rn) begin
            m_pc = END_R;
            m_pilha.delete();
            m_erro = 1'b0;
        end else if (pa) begin
        end else if (re) begin
            if (m_pilha.size() == 0) begin
                m_pc = m_pc + 32'd1;
                m_erro = 1'b1;
            end else begin
                m_pc = m_pilha.pop_back();
            end
        end else if (ch) begin
            if (m_pilha.size() == PROF) begin
                void'(m_pilha.pop_front());
                m_erro = 1'b1;
            end
            m_pilha.push_back(m_pc + 32'd1);
            m_pc = al;
        end else if (sa) begin
            m_pc = al;
        end else if (de) begin
            m_pc = m_pc + 32'd1 + ds;
        end else begin
            m_pc = m_pc + 32'd1;
        end
        e.pc = m_pc;
        e.mais = m_pc + 32'd1;
        e.vazia = (m_pilha.size() == 0);
        e.cheia = (m_pilha.size() == PROF);
        e.erro = m_erro;
        fila.push_back(e);
    endtask

    task automatic ciclo(input logic rn, pa, re, ch, sa, de, input logic [31:0] ds, al);
        @(negedge clock);
        reset_n = rn;
        b.parar = pa; b.retorno = re; b.chamada = ch;
        b.salto = sa; b.desvio = de;
        b.deslocamento = ds; b.alvo = al;
        modelo(rn, pa, re, ch, sa, de, ds, al);
    endtask

    // Monitor: the DUT presents a new state after every edge.
    initial begin
        esperado_t e;
        forever begin
            @(posedge clock);
            #1;
            if (fila.size() > 0) begin
                e = fila.pop_front();
                chk("pc_atual", b.pc_atual, e.pc);
                chk("pc_mais", b.pc_mais, e.mais);
                chk("pilha_vazia", {31'd0, b.pilha_vazia}, {31'd0, e.vazia});
                chk("pilha_cheia", {31'd0, b.pilha_cheia}, {31'd0, e.cheia});
                chk("erro_pilha", {31'd0, b.erro_pilha}, {31'd0, e.erro});
            end
        end
    end

    initial begin
        logic rn, pa, re, ch, sa, de;
        logic [31:0] ds, al;
        b.parar = 0; b.retorno = 0; b.chamada = 0; b.salto = 0; b.desvio = 0;
        b.deslocamento = '0; b.alvo = '0;

        ciclo(0, 0, 0, 0, 0, 0, 0, 0);                    // reset
        ciclo(1, 0, 0, 0, 0, 0, 0, 0);                    // 0x101
        ciclo(1, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);        // jump to top of range
        ciclo(1, 0, 0, 0, 0, 0, 0, 0);                    // wraps to 0
        ciclo(1, 0, 0, 0, 1, 0, 0, 32'h20);
        ciclo(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFB, 0);        // 0x20+1-5 = 0x1C
        ciclo(1, 0, 0, 0, 1, 1, 32'hFFFF_FFFB, 32'h80);   // salto beats desvio
        ciclo(1, 0, 0, 0, 1, 0, 0, 32'h10);
        for (int i = 0; i < 5; i++)                       // calls from 0x10..0x50
            ciclo(1, 0, 0, 1, 0, 0, 0, 32'h20 + 32'(i) * 32'h10);
        for (int i = 0; i < 5; i++)                       // 0x51,0x41,0x31,0x21, underflow 0x22
            ciclo(1, 0, 1, 0, 0, 0, 0, 0);
        ciclo(0, 0, 0, 0, 0, 0, 0, 0);
        ciclo(1, 0, 0, 1, 0, 0, 0, 32'h200);
        ciclo(1, 1, 1, 1, 0, 0, 0, 32'h300);              // stall holds everything
        ciclo(1, 0, 1, 1, 0, 0, 0, 32'h300);              // retorno wins over chamada
        ciclo(1, 0, 0, 1, 0, 0, 0, 32'h400);
        ciclo(1, 0, 0, 1, 0, 0, 0, 32'h500);
        ciclo(0, 0, 0, 1, 0, 0, 0, 32'h600);              // reset beats chamada
        ciclo(1, 0, 1, 0, 0, 0, 0, 0);                    // underflow after reset

        for (int n = 0; n < 400; n++) begin
            rn = ($urandom_range(0, 59) != 0);
            pa = ($urandom_range(0, 9) == 0);
            re = ($urandom_range(0, 3) == 0);
            ch = ($urandom_range(0, 3) == 0);
            sa = ($urandom_range(0, 4) == 0);
            de = ($urandom_range(0, 2) == 0);
            ds = $urandom_range(0, 1) ? $urandom : (32'($urandom_range(0, 64)) - 32'd32);
            al = $urandom;
            ciclo(rn, pa, re, ch, sa, de, ds, al);
        end

        @(posedge clock);
        #2;
        chk("scoreboard_drained", 32'(fila.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
